// File: rtl/norm_pkg.sv
// Shared definitions for the frame normalization controller.
//   DATA_W   : width of the signed filter-bank sample
//   DEF_MIN  : active min coefficient after reset
//   DEF_MAX  : active max coefficient after reset
//   NUM_W    : width of the divider dividend (255 * range)
//   DEN_W    : width of the divider divisor (range, one bit wider than a sample)
package norm_pkg;

  localparam int DATA_W = 21;
  localparam int NUM_W  = DATA_W + 10;
  localparam int DEN_W  = DATA_W + 1;

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    DIV,
    OUT
  } state_e;

  localparam sample_t DEF_MIN = sample_t'(-510);
  localparam sample_t DEF_MAX = sample_t'(1530);

  // Extremes used to re-arm the running statistics at a frame boundary.
  localparam sample_t SAMPLE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // 255*v as (v<<8)-v, so no multiplier is needed.
  function automatic logic [NUM_W-1:0] mul255(input logic [DEN_W-1:0] v);
    return (NUM_W'(v) << 8) - NUM_W'(v);
  endfunction

endpackage

// File: rtl/norm_frame_ctrl_if.sv
// Pixel stream bus between the filter stage, the normalizer and the writer.
//   in_valid/in_ready/in_data/in_last     : sample side (filter -> normalizer)
//   out_valid/out_ready/out_data/out_last : pixel side  (normalizer -> writer)
// slave  : normalizer view
// master : producer/consumer (environment) view
interface norm_frame_ctrl_if;
  import norm_pkg::*;

  logic        in_valid;
  logic        in_ready;
  sample_t     in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/norm_serial_div.sv
// 8-step restoring divider producing an 8-bit quotient.
//   clk, reset  : clock, synchronous active-high reset
//   start_i     : load dividend/divisor and begin (one cycle pulse)
//   dividend_i  : NUM_W-bit unsigned dividend
//   divisor_i   : DEN_W-bit unsigned divisor
//   done_o      : high in the cycle the last quotient bit is resolved
//   quot_o      : quotient, stable from the cycle after done_o until next start
// The caller guarantees dividend < 256*divisor so 8 bits suffice.
// A zero divisor yields a zero quotient after the usual 8 steps.
module norm_serial_div
  import norm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [NUM_W-1:0] dividend_i,
  input  logic [DEN_W-1:0] divisor_i,
  output logic             done_o,
  output logic [7:0]       quot_o
);

  logic [NUM_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [7:0]       quot_q, quot_d;
  logic [2:0]       step_q, step_d;
  logic             busy_q, busy_d;
  logic [NUM_W-1:0] shifted;
  logic             fits;

  always_comb begin
    shifted = NUM_W'(den_q) << step_q;
    // Zero divisor would otherwise "fit" every step and give 255.
    fits    = (den_q != '0) && (rem_q >= shifted);

    rem_d  = rem_q;
    den_d  = den_q;
    quot_d = quot_q;
    step_d = step_q;
    busy_d = busy_q;

    if (start_i) begin
      rem_d  = dividend_i;
      den_d  = divisor_i;
      quot_d = '0;
      step_d = 3'd7;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (fits) begin
        rem_d          = rem_q - shifted;
        quot_d[step_q] = 1'b1;
      end
      if (step_q == 3'd0) busy_d = 1'b0;
      else                step_d = step_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      den_q  <= '0;
      quot_q <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      quot_q <= quot_d;
      step_q <= step_d;
      busy_q <= busy_d;
    end
  end

  assign done_o = busy_q && (step_q == 3'd0);
  assign quot_o = quot_q;

endmodule

// File: rtl/norm_frame_ctrl.sv
// Per-pixel normalizer: out = floor(255*(A-min)/(max-min)), clamped to 0..255.
//   clk, reset       : clock, synchronous active-high reset
//   bus (slave)      : sample in / pixel out valid-ready streams
//   act_min/act_max  : coefficients currently used for normalization
// One sample at a time: IDLE accepts, PREP forms the clamped dividend,
// DIV runs the 8-step serial divider, OUT holds the pixel until accepted.
// Optional macro NORM_ADAPTIVE_EN: when defined, running min/max of each frame
// (closed by in_last) become the coefficients for the next frame; when
// undefined the coefficients stay at DEF_MIN/DEF_MAX.
module norm_frame_ctrl
  import norm_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  norm_frame_ctrl_if.slave         bus,
  output sample_t                  act_min,
  output sample_t                  act_max
);

  state_e  state_q, state_d;
  sample_t data_q, data_d;
  logic    last_q, last_d;

  logic             accept;
  logic             handshake;
  logic             div_start;
  logic             div_done;
  logic [7:0]       quot;
  logic signed [DATA_W:0] off;
  logic signed [DATA_W:0] rng;
  logic [NUM_W-1:0] num;

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign handshake = (state_q == OUT) && bus.out_ready;
  assign div_start = (state_q == PREP);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        data_d  = bus.in_data;
        last_d  = bus.in_last;
        state_d = PREP;
      end
      PREP: state_d = DIV;
      DIV:  if (div_done) state_d = OUT;
      OUT:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // Clamp in the numerator so the quotient can never exceed 255.
  always_comb begin
    off = {data_q[DATA_W-1], data_q} - {act_min[DATA_W-1], act_min};
    rng = {act_max[DATA_W-1], act_max} - {act_min[DATA_W-1], act_min};
    if (off < 0)        num = '0;
    else if (off > rng) num = mul255($unsigned(rng));
    else                num = mul255($unsigned(off));
  end

  norm_serial_div u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .dividend_i (num),
    .divisor_i  ($unsigned(rng)),
    .done_o     (div_done),
    .quot_o     (quot)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = quot;
  assign bus.out_last  = last_q;

`ifdef NORM_ADAPTIVE_EN
  sample_t run_min_q, run_min_d, run_max_q, run_max_d;
  sample_t act_min_q, act_min_d, act_max_q, act_max_d;

  // Running values already include the last sample when its pixel is taken,
  // since no other sample can be accepted in between.
  always_comb begin
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    act_min_d = act_min_q;
    act_max_d = act_max_q;
    if (accept) begin
      if (bus.in_data < run_min_q) run_min_d = bus.in_data;
      if (bus.in_data > run_max_q) run_max_d = bus.in_data;
    end
    if (handshake && last_q) begin
      act_min_d = run_min_q;
      act_max_d = run_max_q;
      run_min_d = SAMPLE_MAX;
      run_max_d = SAMPLE_MIN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_min_q <= SAMPLE_MAX;
      run_max_q <= SAMPLE_MIN;
      act_min_q <= DEF_MIN;
      act_max_q <= DEF_MAX;
    end else begin
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      act_min_q <= act_min_d;
      act_max_q <= act_max_d;
    end
  end

  assign act_min = act_min_q;
  assign act_max = act_max_q;
`else
  assign act_min = DEF_MIN;
  assign act_max = DEF_MAX;
`endif

endmodule

// File: tb/tb_norm_frame_ctrl.sv
module tb_norm_frame_ctrl;
  import norm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  sample_t act_min, act_max;

  norm_frame_ctrl_if bus();

  norm_frame_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .act_min (act_min),
    .act_max (act_max)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t sb[$];
  int   n_err = 0;
  int   n_checks = 0;

  longint m_amin, m_amax, m_rmin, m_rmax;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [7:0] ref_pix(input longint a, input longint mn, input longint mx);
    longint off, rng;
    off = a - mn;
    rng = mx - mn;
    if (rng <= 0) return 8'd0;
    if (off < 0) return 8'd0;
    if (off > rng) return 8'd255;
    return 8'((255 * off) / rng);
  endfunction

  task automatic model_reset();
    m_amin = -510;
    m_amax = 1530;
    m_rmin = (longint'(1) << (DATA_W-1)) - 1;
    m_rmax = -(longint'(1) << (DATA_W-1));
  endtask

  // Send one sample, wait for its pixel, optionally hold off out_ready for bp cycles.
  task automatic pix(input int a, input bit last, input int bp);
    exp_t e;
    int n;
    logic [7:0] d0;
    logic l0;
    e.d = ref_pix(a, m_amin, m_amax);
    e.l = last;
    sb.push_back(e);
`ifdef NORM_ADAPTIVE_EN
    if (a < m_rmin) m_rmin = a;
    if (a > m_rmax) m_rmax = a;
    if (last) begin
      m_amin = m_rmin;
      m_amax = m_rmax;
      m_rmin = (longint'(1) << (DATA_W-1)) - 1;
      m_rmax = -(longint'(1) << (DATA_W-1));
    end
`endif
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = DATA_W'(a);
    bus.in_last   = last;
    bus.out_ready = (bp == 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd10);
    if (bus.out_valid === 1'b1) begin
      e = sb.pop_front();
      chk("out_data", 32'(bus.out_data), 32'(e.d));
      chk("out_last", 32'(bus.out_last), 32'(e.l));
      d0 = bus.out_data;
      l0 = bus.out_last;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(bus.out_data), 32'(d0));
        chk("hold_last", 32'(bus.out_last), 32'(l0));
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("post_hs_valid", 32'(bus.out_valid), 32'd0);
      chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
      chk("act_min", 32'(act_min), 32'(m_amin));
      chk("act_max", 32'(act_max), 32'(m_amax));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_act_min", 32'(act_min), -32'sd510);
    chk("rst_act_max", 32'(act_max), 32'd1530);
    reset = 1'b0;

    // Default coefficients, including both clamp directions
    pix(0, 1'b0, 0);
    pix(1530, 1'b0, 0);
    pix(-510, 1'b0, 0);
    pix(2000, 1'b0, 0);
    pix(-1000, 1'b0, 0);
    pix(765, 1'b0, 0);

    // Backpressure on the output, then a following sample must still come through
    pix(1000, 1'b1, 5);
    pix(300, 1'b0, 0);

    // Reset in the middle of division drops the sample
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(300);
    bus.in_last  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rdiv_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rdiv_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rdiv_act_min", 32'(act_min), -32'sd510);
    chk("rdiv_act_max", 32'(act_max), 32'd1530);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    chk("rdiv_no_valid", 32'(seen), 32'd0);

    // Frame of three samples; its statistics drive the next frame
    pix(100, 1'b0, 0);
    pix(200, 1'b0, 0);
    pix(300, 1'b1, 0);
    pix(200, 1'b1, 0);

    // Zero-range frame
    pix(50, 1'b0, 0);
    pix(50, 1'b1, 0);
    pix(50, 1'b0, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
